alu_pipe: RTL and testbench

//  Parametrised, pipelined signed ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 67 ++++++
 rtl/alu_pipe.sv | 90 +++++++++
 tb/tb_alu_pipe.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and the result flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRA = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic z;   // C == 0
        logic n;   // C[W-1]
        logic v;   // signed overflow, ADD/SUB only
        logic co;  // ADD carry-out / SUB borrow, else 0
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational signed ALU datapath: (sel, A, B) -> (C, flags).
// ADD/SUB are formed at W+1 bits; SAT != 0 clamps overflowing ADD/SUB results.
module alu_core
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  alu_op_e      sel,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] C,
    output alu_flags_t   flags
);

    localparam int           SH      = $clog2(W);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    logic          is_sub;
    logic [W-1:0]  b_eff;
    logic [W:0]    sum_x;
    logic          ovf;
    logic [W-1:0]  arith;
    logic          lt_s;
    logic [SH-1:0] shamt;

    // SUB is A + (~B + 1); overflow when the addends agree in sign and the sum does not.
    assign is_sub = (sel == OP_SUB);
    assign b_eff  = is_sub ? ((~B) + W'(1)) : B;
    assign sum_x  = {1'b0, A} + {1'b0, b_eff};
    assign ovf    = (A[W-1] == b_eff[W-1]) && (sum_x[W-1] != A[W-1]);
    // On overflow both addends share A's sign, so A[W-1] tells which rail to clamp to.
    assign arith  = ((SAT != 0) && ovf) ? (A[W-1] ? MAX_NEG : MAX_POS) : sum_x[W-1:0];
    assign lt_s   = $signed(A) < $signed(B);
    assign shamt  = B[SH-1:0];

    // Opcode decode and flag generation; Z/N follow the final (possibly clamped) C.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        // NOTE: combinational logic uses blocking '='; Z/N below read C as just computed.
        C        = '0;
        flags    = '0;
        unique case (sel)
            OP_ADD: begin
                C        = arith;
                flags.v  = ovf;
                flags.co = sum_x[W];
            end
            OP_SUB: begin
                C        = arith;
                flags.v  = ovf;
                flags.co = (A < B);
            end
            OP_AND:  C = A & B;
            OP_OR:   C = A | B;
            OP_XOR:  C = A ^ B;
            OP_SLT:  C = {{(W-1){1'b0}}, lt_s};
            OP_SLL:  C = A << shamt;
            OP_SRA:  C = $signed(A) >>> shamt;
            default: C = '0;
        endcase
        flags.z = (C == '0);
        flags.n = C[W-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 holds the accepted operands, S2 holds the registered result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  alu_op_e      sel,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] C,
    output logic         Z,
    output logic         N,
    output logic         V,
    output logic         CO
);

    logic         s1_valid;
    alu_op_e      s1_sel;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_advance;
    logic         s2_advance;
    logic [W-1:0] core_c;
    alu_flags_t   core_flags;

    // S2 moves when empty or handing off; S1 moves whenever S2 can take it.
    // s_ready depends only on state and m_ready, never on s_valid/sel/A/B.
    assign s2_advance = !m_valid || m_ready;
    assign s1_advance = s1_valid && s2_advance;
    assign s_ready    = !s1_valid || s1_advance;

    alu_core #(
        .W   (W),
        .SAT (SAT)
    ) u_core (
        .sel   (s1_sel),
        .A     (s1_a),
        .B     (s1_b),
        .C     (core_c),
        .flags (core_flags)
    );

    // S1: capture operands on accept; refill or empty whenever s_ready is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: payload registers are reset together with the valid bits; they are few and this keeps X out of the core.
            s1_valid <= 1'b0;
            s1_sel   <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s_ready) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_sel <= sel;
                s1_a   <= A;
                s1_b   <= B;
            end
        end
    end

    // S2: register result and flags; everything holds while the sink stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            C       <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            CO      <= 1'b0;
        end else if (s2_advance) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                C  <= core_c;
                Z  <= core_flags.z;
                N  <= core_flags.n;
                V  <= core_flags.v;
                CO <= core_flags.co;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (W=8), with a SAT=1 twin sharing the stimulus.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       s_valid;
    logic       s_ready, s_ready_s;
    alu_op_e    sel;
    logic [7:0] a, b;
    logic       m_valid, m_valid_s;
    logic       m_ready;
    logic [7:0] c, c_s;
    logic       z, n, v, co;
    logic       z_s, n_s, v_s, co_s;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.W(8), .SAT(0)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .sel(sel), .A(a), .B(b), .m_valid(m_valid), .m_ready(m_ready),
        .C(c), .Z(z), .N(n), .V(v), .CO(co)
    );

    alu_pipe #(.W(8), .SAT(1)) dut_sat (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_s),
        .sel(sel), .A(a), .B(b), .m_valid(m_valid_s), .m_ready(m_ready),
        .C(c_s), .Z(z_s), .N(n_s), .V(v_s), .CO(co_s)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One beat with m_ready=1; checks latency and both DUTs' result.
    // Flags are compared as {Z,N,V,CO}. Entered and left on a negedge.
    task automatic alu_vec(input string tag, input alu_op_e op, input logic [7:0] va,
                           input logic [7:0] vb, input logic [7:0] exp_c, input logic [3:0] exp_f,
                           input logic [7:0] exp_cs, input logic [3:0] exp_fs);
        sel = op; a = va; b = vb; s_valid = 1'b1;
        check({tag, "_sready"}, 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, 32'(m_valid), 32'd1);
        check({tag, "_c"}, 32'(c), 32'(exp_c));
        check({tag, "_f"}, 32'({z, n, v, co}), 32'(exp_f));
        check({tag, "_sat_c"}, 32'(c_s), 32'(exp_cs));
        check({tag, "_sat_f"}, 32'({z_s, n_s, v_s, co_s}), 32'(exp_fs));
    endtask

    localparam int NBP = 5;
    alu_op_e    bp_op [NBP] = '{OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_ADD};
    logic [7:0] bp_a  [NBP] = '{8'd1, 8'd10, 8'h0F, 8'd3, 8'h7F};
    logic [7:0] bp_b  [NBP] = '{8'd2, 8'd3,  8'hFF, 8'd2, 8'h01};
    logic [7:0] bp_c  [NBP] = '{8'd3, 8'd7,  8'hF0, 8'd12, 8'h80};

    initial begin
        int         cyc, idx, rx;
        logic       acc, prev_stall;
        logic [7:0] prev_c;
        logic [3:0] prev_f;

        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        sel = OP_ADD; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_sready", 32'(s_ready), 32'd1);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_f", 32'({z, n, v, co}), 32'd0);
        check("rst_sat_c", 32'(c_s), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        //                  op      A      B      C      ZNVC     C_sat  ZNVC_sat
        alu_vec("add_127", OP_ADD, 8'd100, 8'd27, 8'h7F, 4'b0000, 8'h7F, 4'b0000);
        alu_vec("add_ovf", OP_ADD, 8'd100, 8'd28, 8'h80, 4'b0110, 8'h7F, 4'b0010);
        alu_vec("add_co",  OP_ADD, 8'hC8,  8'h64, 8'h2C, 4'b0001, 8'h2C, 4'b0001);
        alu_vec("sub_eq",  OP_SUB, 8'd5,   8'd5,  8'h00, 4'b1000, 8'h00, 4'b1000);
        alu_vec("sub_brw", OP_SUB, 8'd0,   8'd1,  8'hFF, 4'b0101, 8'hFF, 4'b0101);
        alu_vec("sub_ovf", OP_SUB, 8'h80,  8'd1,  8'h7F, 4'b0010, 8'h80, 4'b0110);
        alu_vec("and",     OP_AND, 8'hF0,  8'h3C, 8'h30, 4'b0000, 8'h30, 4'b0000);
        alu_vec("or",      OP_OR,  8'hF0,  8'h0C, 8'hFC, 4'b0100, 8'hFC, 4'b0100);
        alu_vec("xor",     OP_XOR, 8'hAA,  8'hAA, 8'h00, 4'b1000, 8'h00, 4'b1000);
        alu_vec("slt_t",   OP_SLT, 8'hFD,  8'd2,  8'h01, 4'b0000, 8'h01, 4'b0000);
        alu_vec("slt_f",   OP_SLT, 8'd2,   8'hFD, 8'h00, 4'b1000, 8'h00, 4'b1000);
        alu_vec("sra",     OP_SRA, 8'h80,  8'd3,  8'hF0, 4'b0100, 8'hF0, 4'b0100);
        alu_vec("sll_7",   OP_SLL, 8'd1,   8'd7,  8'h80, 4'b0100, 8'h80, 4'b0100);
        alu_vec("sll_9",   OP_SLL, 8'd1,   8'd9,  8'h02, 4'b0000, 8'h02, 4'b0000);

        // Let the last result drain before stalling the sink.
        repeat (2) @(negedge clk);
        check("idle_mvalid", 32'(m_valid), 32'd0);

        // Backpressure: five back-to-back beats, m_ready low for the first 4 cycles.
        cyc = 0; idx = 0; rx = 0; prev_stall = 1'b0; prev_c = '0; prev_f = '0;
        m_ready = 1'b0;
        sel = bp_op[0]; a = bp_a[0]; b = bp_b[0]; s_valid = 1'b1;
        while (rx < NBP && cyc < 60) begin
            if (prev_stall) begin
                check("bp_hold_c", 32'(c), 32'(prev_c));
                check("bp_hold_f", 32'({z, n, v, co}), 32'(prev_f));
            end
            if (cyc == 3) begin
                check("bp_sready_low", 32'(s_ready), 32'd0);
                check("bp_accepts", 32'(idx), 32'd2);
            end
            if (m_valid && m_ready) begin
                check($sformatf("bp_c%0d", rx), 32'(c), 32'(bp_c[rx]));
                rx++;
            end
            acc        = s_valid && s_ready;
            prev_stall = m_valid && !m_ready;
            prev_c     = c;
            prev_f     = {z, n, v, co};
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            m_ready = (cyc >= 4);
            if (idx < NBP) begin
                sel = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx]; s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("bp_received", 32'(rx), 32'(NBP));

        // Reset mid-stream with two beats in flight.
        repeat (2) @(negedge clk);
        m_ready = 1'b0;
        sel = OP_ADD; a = 8'd1; b = 8'd1; s_valid = 1'b1;
        @(posedge clk); #1;
        sel = OP_OR; a = 8'h40; b = 8'h02;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("mid_mvalid_pre", 32'(m_valid), 32'd1);
        check("mid_sready_pre", 32'(s_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("mid_mvalid_rst", 32'(m_valid), 32'd0);
        check("mid_sready_rst", 32'(s_ready), 32'd1);
        check("mid_c_rst", 32'(c), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        alu_vec("mid_new", OP_AND, 8'h0F, 8'h35, 8'h05, 4'b0000, 8'h05, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
